// File: rtl/rsa_decrypt_engine_if.sv
// Handshake and operand/result bundle for the RSA decryption engine.
// The master drives the request side; the engine is the slave.
interface rsa_decrypt_engine_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] M;
    logic             busy;
    logic             finish;
    logic             error;

    modport master (
        output start, C, d, n,
        input  M, busy, finish, error
    );

    modport slave (
        input  start, C, d, n,
        output M, busy, finish, error
    );
endinterface

// File: rtl/rsa_decrypt_engine.sv
// RSA decryption M = C^d mod n: MSB-first square-and-multiply on top of a
// bit-serial interleaved modular multiplier, one multiplier step per clock.
module rsa_decrypt_engine #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    rsa_decrypt_engine_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

    state_t           state_r;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH+1:0] acc_r;
    logic [IW-1:0]    bit_r;
    logic [IW-1:0]    exp_r;
    logic [WIDTH-1:0] m_r;
    logic             busy_r;
    logic             finish_r;
    logic             error_r;

    logic [WIDTH-1:0] mul_b_s;
    logic [WIDTH+1:0] acc_next_s;
    logic [WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] mul_res_s;
    logic             illegal_s;

    // One interleaved step: 2*acc + (sel ? b : 0), then fold back below n.
    // acc < n on entry, so the sum is below 3n and two subtractions suffice.
    function automatic logic [WIDTH+1:0] mod_step(
        input logic [WIDTH+1:0] acc,
        input logic [WIDTH-1:0] b,
        input logic             sel,
        input logic [WIDTH-1:0] modulus
    );
        logic [WIDTH+1:0] s;
        logic [WIDTH+1:0] nn;
        nn = {2'b00, modulus};
        if (sel) begin
            s = {acc[WIDTH:0], 1'b0} + {2'b00, b};
        end else begin
            s = {acc[WIDTH:0], 1'b0};
        end
        if (s >= nn) begin
            s = s - nn;
        end else begin
            s = s;
        end
        if (s >= nn) begin
            s = s - nn;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // Multiplier datapath: squaring uses R for both operands, multiply uses R*C.
    always_comb begin
        mul_b_s    = r_r;
        if (state_r == MUL) begin
            mul_b_s = c_r;
        end else begin
            mul_b_s = r_r;
        end
        acc_next_s = mod_step(acc_r, mul_b_s, r_r[bit_r], n_r);
        prod_s     = acc_next_s[WIDTH-1:0];
        if (d_r[exp_r]) begin
            mul_res_s = prod_s;
        end else begin
            mul_res_s = r_r;
        end
        illegal_s  = (n_r < WIDTH'(2)) || (c_r >= n_r);
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            c_r      <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            n_r      <= {WIDTH{1'b0}};
            r_r      <= {WIDTH{1'b0}};
            acc_r    <= {(WIDTH+2){1'b0}};
            bit_r    <= {IW{1'b0}};
            exp_r    <= {IW{1'b0}};
            m_r      <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    finish_r <= 1'b0;
                    if (bus.start) begin
                        c_r     <= bus.C;
                        d_r     <= bus.d;
                        n_r     <= bus.n;
                        m_r     <= {WIDTH{1'b0}};
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (illegal_s) begin
                        m_r      <= {WIDTH{1'b0}};
                        error_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        finish_r <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        r_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
                        acc_r   <= {(WIDTH+2){1'b0}};
                        bit_r   <= TOP_IDX;
                        exp_r   <= TOP_IDX;
                        state_r <= SQR;
                    end
                end
                SQR: begin
                    if (bit_r == {IW{1'b0}}) begin
                        r_r     <= prod_s;
                        acc_r   <= {(WIDTH+2){1'b0}};
                        bit_r   <= TOP_IDX;
                        state_r <= MUL;
                    end else begin
                        acc_r <= acc_next_s;
                        bit_r <= bit_r - 1'b1;
                    end
                end
                MUL: begin
                    if (bit_r == {IW{1'b0}}) begin
                        r_r   <= mul_res_s;
                        acc_r <= {(WIDTH+2){1'b0}};
                        bit_r <= TOP_IDX;
                        if (exp_r == {IW{1'b0}}) begin
                            m_r      <= mul_res_s;
                            busy_r   <= 1'b0;
                            finish_r <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            exp_r   <= exp_r - 1'b1;
                            state_r <= SQR;
                        end
                    end else begin
                        acc_r <= acc_next_s;
                        bit_r <= bit_r - 1'b1;
                    end
                end
                DONE: begin
                    finish_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r   <= 1'b0;
                    finish_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign bus.M      = m_r;
    assign bus.busy   = busy_r;
    assign bus.finish = finish_r;
    assign bus.error  = error_r;
endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Directed bench for rsa_decrypt_engine: latency, results, illegal operands,
// ignored mid-job starts and reset abort.
module tb_rsa_decrypt_engine;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fin_cnt;
    int   proto_bad;
    logic prev_fin;

    rsa_decrypt_engine_if #(.WIDTH(16)) bus ();

    rsa_decrypt_engine #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Finish pulse counter and handshake sanity (no double finish, no busy with finish).
    always @(negedge clk) begin
        if (bus.finish === 1'b1) begin
            fin_cnt = fin_cnt + 1;
            if (bus.busy !== 1'b0 || prev_fin === 1'b1) proto_bad = proto_bad + 1;
        end
        prev_fin = bus.finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [15:0] c, input logic [15:0] dd,
                           input logic [15:0] nn, input int exp_lat,
                           input logic [15:0] exp_m, input logic exp_err);
        int off;
        int busy_low;
        int fin0;
        fin0 = fin_cnt;
        bus.C = c; bus.d = dd; bus.n = nn; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        off = 1;
        busy_low = 0;
        while (bus.finish !== 1'b1 && off < 700) begin
            if (bus.busy !== 1'b1) busy_low = busy_low + 1;
            tick();
            off = off + 1;
        end
        chk({tag, "_latency"}, off, exp_lat);
        chk({tag, "_busy"}, busy_low, 0);
        chk({tag, "_M"}, bus.M, exp_m);
        chk({tag, "_error"}, bus.error, exp_err);
        tick();
        chk({tag, "_finish_drop"}, bus.finish, 1'b0);
        chk({tag, "_finish_count"}, fin_cnt - fin0, 1);
    endtask

    initial begin
        int off;
        int fin0;
        checks = 0; errors = 0; fin_cnt = 0; proto_bad = 0; prev_fin = 1'b0;
        bus.start = 1'b0; bus.C = 16'd0; bus.d = 16'd0; bus.n = 16'd0;
        reset = 1'b1;
        tick(); tick();
        chk("rst_M", bus.M, 16'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_finish", bus.finish, 1'b0);
        chk("rst_error", bus.error, 1'b0);
        reset = 1'b0;
        tick();

        run_job("pow2_10", 16'd2, 16'd10, 16'd1000, 514, 16'd24, 1'b0);
        run_job("rsa_dec", 16'd3156, 16'd1373, 16'd3551, 514, 16'd1256, 1'b0);
        run_job("rsa_enc", 16'd1256, 16'd5, 16'd3551, 514, 16'd3156, 1'b0);
        run_job("d_zero", 16'd1234, 16'd0, 16'd3551, 514, 16'd1, 1'b0);
        run_job("c_zero", 16'd0, 16'd7, 16'd3551, 514, 16'd0, 1'b0);
        run_job("c_one", 16'd1, 16'd1373, 16'd3551, 514, 16'd1, 1'b0);
        run_job("minus1_sq", 16'd3550, 16'd2, 16'd3551, 514, 16'd1, 1'b0);

        run_job("n_one", 16'd0, 16'd3, 16'd1, 2, 16'd0, 1'b1);
        tick(); tick();
        chk("err_held", bus.error, 1'b1);
        run_job("c_eq_n", 16'd3551, 16'd3, 16'd3551, 2, 16'd0, 1'b1);
        run_job("err_clear", 16'd2, 16'd10, 16'd1000, 514, 16'd24, 1'b0);

        // Starts during a job and operand changes after acceptance are ignored.
        fin0 = fin_cnt;
        bus.C = 16'd2; bus.d = 16'd10; bus.n = 16'd1000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.C = 16'd5; bus.d = 16'd3; bus.n = 16'd7;
        off = 1;
        while (bus.finish !== 1'b1 && off < 700) begin
            bus.start = (off == 5 || off == 300) ? 1'b1 : 1'b0;
            tick();
            bus.start = 1'b0;
            off = off + 1;
        end
        chk("midstart_latency", off, 514);
        chk("midstart_M", bus.M, 16'd24);
        tick();
        repeat (10) tick();
        chk("midstart_finish_count", fin_cnt - fin0, 1);
        chk("midstart_idle_busy", bus.busy, 1'b0);

        // Reset mid-job aborts without a finish pulse.
        fin0 = fin_cnt;
        bus.C = 16'd1256; bus.d = 16'd5; bus.n = 16'd3551; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 200; i++) tick();
        chk("pre_rst_busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_M", bus.M, 16'd0);
        chk("abort_finish", bus.finish, 1'b0);
        repeat (20) tick();
        chk("abort_no_finish", fin_cnt - fin0, 0);
        run_job("after_rst", 16'd3156, 16'd1373, 16'd3551, 514, 16'd1256, 1'b0);

        chk("protocol", proto_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rsa_decrypt_engine.md
Name: rsa_decrypt_engine

Overview:
Client-side counterpart of the server-side RSA key-generation/encryption block: recovers plaintext M = C^d mod n from a ciphertext C and the private key pair (d, n) produced by the server side. Sequential MSB-first square-and-multiply exponentiation built on a bit-serial interleaved modular multiplier, one multiplier step per clock, fixed latency independent of data. Start/finish handshake matching the server-side blocks; no division hardware.

Parameters:
WIDTH, 16, bit width of C, d, n and M (n = p*q for 8-bit primes fits in 16 bits)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; C, d and n sampled on the accepting edge
C  input  WIDTH  ciphertext
d  input  WIDTH  private exponent
n  input  WIDTH  modulus
M  output  WIDTH  decrypted plaintext; valid from the finish cycle, held until next accepted start
busy  output  1  high from the cycle after acceptance until finish
finish  output  1  one-cycle completion pulse
error  output  1  set with finish when operands are illegal; held until next accepted start

Behaviour:
- Reset (clk edge with reset=1): state IDLE, M=0, busy=0, finish=0, error=0, internal registers cleared. Reset overrides everything, including mid-operation; no finish is produced for the aborted job.
- States: IDLE -> LOAD -> SQR -> MUL -> (SQR for next bit | DONE) -> IDLE.
- IDLE: start=1 at edge T accepted; registers C, d, n internally; input changes afterwards ignored. start while busy or in DONE ignored (no queueing).
- LOAD (cycle T+1, busy=1): if n<2 or C>=n -> DONE with error=1, M=0 (finish in cycle T+2). Else R=1, bit index k=WIDTH-1, -> SQR.
- Modular multiply a*b mod n, WIDTH cycles: acc=0; for i=WIDTH-1..0: acc = 2*acc + (a[i] ? b : 0), then subtract n while acc>=n (at most two subtractions, single cycle). Invariant acc<n; intermediate < 3n, accumulator WIDTH+2 bits.
- SQR: R = R*R mod n (WIDTH cycles). MUL: t = R*C mod n (WIDTH cycles); R = d[k] ? t : R. MUL always executes regardless of d[k] (constant latency). After MUL: k==0 -> DONE, else k-=1, -> SQR.
- Total: 1 LOAD + 2*WIDTH*WIDTH compute cycles; DONE in cycle T+2+2*WIDTH^2 (T+514 for WIDTH=16): finish=1, busy=0, M=R, error=0. Next cycle IDLE; start in that cycle is accepted.
- d=0 gives M=1; C=0 gives M=0 (d>0); C=1 gives 1.
- finish never high two consecutive cycles; busy and finish never high together.

Test Plan:
- reset, then C=2, d=10, n=1000, start pulse at T -> finish exactly at T+514, M=24, error=0; busy high T+1..T+513.
- RSA round trip with p=67, q=53 (n=3551), e=5, d=1373: C=3156 -> M=1256; also C=1256^5 mod 3551 check via d=5, C=1256 -> M=3156.
- Edge values: d=0, C=1234, n=3551 -> M=1; C=0, d=7 -> M=0; C=3550, d=2, n=3551 -> M=1.
- Illegal operands: n=1 -> finish at T+2, error=1, M=0; C=3551, n=3551 -> same; following legal job clears error.
- Start pulses at T+5 and T+300 during a job, inputs changed at T+1 -> ignored; single finish at T+514 with result from operands sampled at T.
- reset asserted at T+200 -> next cycle busy=0, M=0, no finish; new start afterward completes normally with correct M.
